// File: rtl/scene_phase_sequencer.sv
// Frame-synchronous twilight scene sequencer: walks night -> dawn -> day -> dusk,
// owning the shared fade level and the compositor layer mask.
module scene_phase_sequencer #(
    parameter int unsigned NIGHT_FRAMES = 120,
    parameter int unsigned DAY_FRAMES   = 180,
    parameter int unsigned RAMP_STEP    = 2,
    parameter int unsigned HOLD_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       pause,
    input  logic       restart,
    input  logic [1:0] speed,
    output logic [7:0] fade_level,
    output logic [1:0] phase,
    output logic [3:0] layer_en,
    output logic       cycle_done
);

    localparam int unsigned FADE_W  = 8;
    localparam int unsigned CALC_W  = 11;
    localparam int unsigned LAYER_W = 4;

    localparam logic [HOLD_W-1:0]  NIGHT_LAST  = HOLD_W'(NIGHT_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  DAY_LAST    = HOLD_W'(DAY_FRAMES - 1);
    localparam logic [CALC_W-1:0]  FADE_MAX    = CALC_W'(255);
    localparam logic [CALC_W-1:0]  BASE_STEP   = CALC_W'(RAMP_STEP);
    localparam logic [FADE_W-1:0]  SUN_MIN     = FADE_W'(32);
    localparam logic [FADE_W-1:0]  STARS_LIMIT = FADE_W'(128);
    localparam logic [LAYER_W-1:0] LAYER_RST   = LAYER_W'(4'b1011);

    typedef enum logic [1:0] {
        NIGHT_HOLD = 2'd0,
        DAWN_RAMP  = 2'd1,
        DAY_HOLD   = 2'd2,
        DUSK_RAMP  = 2'd3
    } phase_e;

    phase_e              state_q, state_d;
    logic [FADE_W-1:0]   fade_q, fade_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [LAYER_W-1:0]  layer_q, layer_d;
    logic                done_q, done_d;
    logic                vsync_q;

    logic                tick_c;
    logic                adv_c;
    logic [CALC_W-1:0]   step_c;
    logic [CALC_W-1:0]   fade_ext_c;
    logic [CALC_W-1:0]   sum_c;
    logic [CALC_W-1:0]   diff_c;

    // Falling edge of the active-low vsync marks the start of a frame.
    assign tick_c     = vsync_q & ~vsync;
    assign adv_c      = tick_c & ~pause;
    assign step_c     = BASE_STEP << speed;
    assign fade_ext_c = CALC_W'(fade_q);
    assign sum_c      = fade_ext_c + step_c;
    assign diff_c     = fade_ext_c - step_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NIGHT_HOLD;
            fade_q  <= '0;
            cnt_q   <= '0;
            layer_q <= LAYER_RST;
            done_q  <= 1'b0;
            vsync_q <= 1'b1;
        end else begin
            state_q <= state_d;
            fade_q  <= fade_d;
            cnt_q   <= cnt_d;
            layer_q <= layer_d;
            done_q  <= done_d;
            vsync_q <= vsync;
        end
    end

    always_comb begin
        state_d = state_q;
        fade_d  = fade_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (restart) begin
            state_d = NIGHT_HOLD;
            fade_d  = '0;
            cnt_d   = '0;
        end else if (adv_c) begin
            case (state_q)
                NIGHT_HOLD: begin
                    if (cnt_q == NIGHT_LAST) begin
                        state_d = DAWN_RAMP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + HOLD_W'(1);
                    end
                end
                DAWN_RAMP: begin
                    if (sum_c >= FADE_MAX) begin
                        fade_d  = FADE_W'(8'hFF);
                        state_d = DAY_HOLD;
                        cnt_d   = '0;
                    end else begin
                        fade_d = FADE_W'(sum_c);
                    end
                end
                DAY_HOLD: begin
                    if (cnt_q == DAY_LAST) begin
                        state_d = DUSK_RAMP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + HOLD_W'(1);
                    end
                end
                DUSK_RAMP: begin
                    if (step_c >= fade_ext_c) begin
                        fade_d  = '0;
                        state_d = NIGHT_HOLD;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        fade_d = FADE_W'(diff_c);
                    end
                end
                default: begin
                    state_d = NIGHT_HOLD;
                    fade_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Mask follows the fade value being registered so both always agree.
        layer_d = {1'b1, (fade_d >= SUN_MIN), (fade_d < STARS_LIMIT), 1'b1};
    end

    assign fade_level = fade_q;
    assign phase      = state_q;
    assign layer_en   = layer_q;
    assign cycle_done = done_q;

endmodule

// File: tb/tb_scene_phase_sequencer.sv
// Directed bench: instance A (night 4, day 2, step 100) covers phases, pause,
// restart and reset; instance B (night 1, step 1) covers the speed multiplier.
module tb_scene_phase_sequencer;

    logic       clk;
    logic       rst_n;

    logic       vsync_a, pause_a, restart_a;
    logic [1:0] speed_a;
    logic [7:0] fade_a;
    logic [1:0] phase_a;
    logic [3:0] layer_a;
    logic       done_a;

    logic       vsync_b, pause_b, restart_b;
    logic [1:0] speed_b;
    logic [7:0] fade_b;
    logic [1:0] phase_b;
    logic [3:0] layer_b;
    logic       done_b;

    int n_tests = 0;
    int n_fail  = 0;

    scene_phase_sequencer #(
        .NIGHT_FRAMES(4), .DAY_FRAMES(2), .RAMP_STEP(100), .HOLD_W(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .vsync(vsync_a), .pause(pause_a),
        .restart(restart_a), .speed(speed_a), .fade_level(fade_a),
        .phase(phase_a), .layer_en(layer_a), .cycle_done(done_a)
    );

    scene_phase_sequencer #(
        .NIGHT_FRAMES(1), .DAY_FRAMES(1), .RAMP_STEP(1), .HOLD_W(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .vsync(vsync_b), .pause(pause_b),
        .restart(restart_b), .speed(speed_b), .fade_level(fade_b),
        .phase(phase_b), .layer_en(layer_b), .cycle_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One frame on A: vsync low for `hold` clocks, then high again; ends on a negedge.
    task automatic tick_a(input int hold);
        @(negedge clk) vsync_a = 1'b0;
        repeat (hold) @(negedge clk);
        vsync_a = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic tick_b();
        @(negedge clk) vsync_b = 1'b0;
        repeat (2) @(negedge clk);
        vsync_b = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        vsync_a = 1'b1; pause_a = 1'b0; restart_a = 1'b0; speed_a = 2'd0;
        vsync_b = 1'b1; pause_b = 1'b0; restart_b = 1'b0; speed_b = 2'd0;
        #12;
        check_eq("rst fade", 32'(fade_a), 32'd0);
        check_eq("rst phase", 32'(phase_a), 32'd0);
        check_eq("rst layer", 32'(layer_a), 32'hB);
        check_eq("rst done", 32'(done_a), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Speed multiplier on B: step 8 at speed 3, then 1 after switching to 0.
        speed_b = 2'd3;
        tick_b();
        check_eq("b night exit", 32'(phase_b), 32'd1);
        tick_b();
        check_eq("b fade x8 #1", 32'(fade_b), 32'd8);
        tick_b();
        check_eq("b fade x8 #2", 32'(fade_b), 32'd16);
        speed_b = 2'd0;
        tick_b();
        check_eq("b fade x1 #1", 32'(fade_b), 32'd17);
        tick_b();
        check_eq("b fade x1 #2", 32'(fade_b), 32'd18);
        check_eq("b still dawn", 32'(phase_b), 32'd1);

        // Idle with vsync high: nothing moves.
        repeat (20) @(negedge clk);
        check_eq("idle phase", 32'(phase_a), 32'd0);
        check_eq("idle fade", 32'(fade_a), 32'd0);

        // Night hold of 4 frames; the long-low frame must count once.
        tick_a(2);
        check_eq("night t1", 32'(phase_a), 32'd0);
        tick_a(100);
        check_eq("night t2 long low", 32'(phase_a), 32'd0);
        tick_a(2);
        check_eq("night t3", 32'(phase_a), 32'd0);
        tick_a(2);
        check_eq("night t4 phase", 32'(phase_a), 32'd1);
        check_eq("night t4 fade", 32'(fade_a), 32'd0);

        // Dawn saturation.
        tick_a(2);
        check_eq("dawn 100 fade", 32'(fade_a), 32'd100);
        check_eq("dawn 100 layer", 32'(layer_a), 32'hF);
        tick_a(2);
        check_eq("dawn 200 fade", 32'(fade_a), 32'd200);
        check_eq("dawn 200 layer", 32'(layer_a), 32'hD);
        check_eq("dawn 200 phase", 32'(phase_a), 32'd1);
        tick_a(2);
        check_eq("dawn 255 fade", 32'(fade_a), 32'd255);
        check_eq("dawn 255 phase", 32'(phase_a), 32'd2);

        // Day hold of 2 frames, then dusk.
        tick_a(2);
        check_eq("day t1", 32'(phase_a), 32'd2);
        tick_a(2);
        check_eq("day t2", 32'(phase_a), 32'd3);
        check_eq("day t2 fade", 32'(fade_a), 32'd255);
        tick_a(2);
        check_eq("dusk 155 fade", 32'(fade_a), 32'd155);
        check_eq("dusk 155 layer", 32'(layer_a), 32'hD);
        tick_a(2);
        check_eq("dusk 55 fade", 32'(fade_a), 32'd55);
        check_eq("dusk 55 layer", 32'(layer_a), 32'hF);
        check_eq("dusk pre done", 32'(done_a), 32'd0);

        // Final dusk step: cycle_done high for exactly one clock.
        @(negedge clk) vsync_a = 1'b0;
        @(posedge clk); #1;
        check_eq("dusk end fade", 32'(fade_a), 32'd0);
        check_eq("dusk end phase", 32'(phase_a), 32'd0);
        check_eq("dusk end layer", 32'(layer_a), 32'hB);
        check_eq("done pulse", 32'(done_a), 32'd1);
        @(posedge clk); #1;
        check_eq("done drops", 32'(done_a), 32'd0);
        @(negedge clk) vsync_a = 1'b1;
        repeat (2) @(negedge clk);

        // Back through night into dawn, then pause over 10 frames.
        repeat (4) tick_a(2);
        check_eq("night2 exit", 32'(phase_a), 32'd1);
        pause_a = 1'b1;
        repeat (10) tick_a(2);
        check_eq("pause fade", 32'(fade_a), 32'd0);
        check_eq("pause phase", 32'(phase_a), 32'd1);
        pause_a = 1'b0;
        tick_a(2);
        check_eq("unpause fade", 32'(fade_a), 32'd100);
        tick_a(2);
        tick_a(2);
        check_eq("day2 entry", 32'(phase_a), 32'd2);
        tick_a(2);
        check_eq("day2 t1", 32'(phase_a), 32'd2);

        // Restart coincident with a tick in day hold.
        @(negedge clk) begin vsync_a = 1'b0; restart_a = 1'b1; end
        @(negedge clk) restart_a = 1'b0;
        check_eq("restart fade", 32'(fade_a), 32'd0);
        check_eq("restart phase", 32'(phase_a), 32'd0);
        check_eq("restart layer", 32'(layer_a), 32'hB);
        check_eq("restart done", 32'(done_a), 32'd0);
        @(negedge clk) vsync_a = 1'b1;
        check_eq("restart done later", 32'(done_a), 32'd0);
        repeat (2) @(negedge clk);
        repeat (3) tick_a(2);
        check_eq("restart cnt t3", 32'(phase_a), 32'd0);
        tick_a(2);
        check_eq("restart cnt t4", 32'(phase_a), 32'd1);
        tick_a(2);
        check_eq("pre-reset fade", 32'(fade_a), 32'd100);

        // Asynchronous reset mid-ramp, away from any clock edge.
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check_eq("async rst fade", 32'(fade_a), 32'd0);
        check_eq("async rst phase", 32'(phase_a), 32'd0);
        check_eq("async rst layer", 32'(layer_a), 32'hB);
        check_eq("async rst done", 32'(done_a), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("post rst idle phase", 32'(phase_a), 32'd0);
        check_eq("post rst idle fade", 32'(fade_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
